// File: rtl/fifo2linebuf.sv
// fifo2linebuf
//   Pops 29-bit pixel words ({1'bx, half, y[10:0], yuv[15:0]}) from the video RX FIFO
//   and writes each pixel into a ping-pong line buffer. The bank is y[0]. Each line is
//   announced to the HDMI-side reader once both halves have arrived in full. Abandoned
//   lines and excess pixels are each reported with a one-cycle pulse.
//
// Ports
//   clk125_i        125 MHz system clock
//   sys_rst_i       asynchronous, active-high reset
//   fifo_dout_i     RX FIFO read data, valid one cycle after fifo_rd_en_o
//   fifo_empty_i    RX FIFO empty
//   fifo_rd_en_o    RX FIFO pop (combinational)
//   lb_we_o         line-buffer write strobe
//   lb_bank_o       line-buffer bank of this write
//   lb_addr_o       half*PIX_PER_PKT + pixel index
//   lb_data_o       YUV pixel
//   line_done_o     one-cycle pulse: a line is complete in line_bank_o
//   line_y_o        y of the last completed line (held)
//   line_bank_o     bank of the last completed line (held)
//   bank_release_i  one-cycle pulse per bank: reader is done with that bank
//   bank_busy_o     bank holds a completed line that has not been released
//   line_drop_o     one-cycle pulse: an incomplete line was abandoned
//   pix_ovf_o       one-cycle pulse: an excess pixel was discarded
module fifo2linebuf #(
    parameter int unsigned PIX_PER_PKT = 640,
    parameter int unsigned ADDR_W      = 11
) (
    input  logic              clk125_i,
    input  logic              sys_rst_i,
    input  logic [28:0]       fifo_dout_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    output logic              lb_we_o,
    output logic              lb_bank_o,
    output logic [ADDR_W-1:0] lb_addr_o,
    output logic [15:0]       lb_data_o,
    output logic              line_done_o,
    output logic [10:0]       line_y_o,
    output logic              line_bank_o,
    input  logic [1:0]        bank_release_i,
    output logic [1:0]        bank_busy_o,
    output logic              line_drop_o,
    output logic              pix_ovf_o
);

    localparam int unsigned       IDX_W    = $clog2(PIX_PER_PKT + 1);
    localparam logic [IDX_W-1:0]  IdxFull  = IDX_W'(PIX_PER_PKT);
    localparam logic [ADDR_W-1:0] HalfBase = ADDR_W'(PIX_PER_PKT);

    // Bit 28 of the FIFO word carries no information for this block.
    logic unused_fifo_bit;
    assign unused_fifo_bit = fifo_dout_i[28];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [27:0]       skid0_q, skid0_d;
    logic [27:0]       skid1_q, skid1_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic              pend_q, pend_d;       // a pop was issued last cycle
    logic [10:0]       cur_y_q, cur_y_d;
    logic              cur_valid_q, cur_valid_d;
    logic [IDX_W-1:0]  idx0_q, idx0_d;
    logic [IDX_W-1:0]  idx1_q, idx1_d;
    logic              lb_we_q, lb_we_d;
    logic              lb_bank_q, lb_bank_d;
    logic [ADDR_W-1:0] lb_addr_q, lb_addr_d;
    logic [15:0]       lb_data_q, lb_data_d;
    logic              line_done_q, line_done_d;
    logic [10:0]       line_y_q, line_y_d;
    logic              line_bank_q, line_bank_d;
    logic [1:0]        busy_q, busy_d;
    logic              line_drop_q, line_drop_d;
    logic              pix_ovf_q, pix_ovf_d;

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    // Occupancy counts the in-flight word too, so the skid never overflows.
    logic [1:0] occ;
    assign occ = skid_cnt_q + {1'b0, pend_q};

    always_comb begin
        fifo_rd_en_o = !sys_rst_i && !fifo_empty_i && (occ < 2'd2);
    end

    // Head of the skid; with an empty skid the word arriving from the FIFO is
    // processed directly, which gives the two-cycle pop-to-write latency.
    logic        head_valid;
    logic [27:0] head;
    logic        h_half;
    logic [10:0] h_y;
    logic [15:0] h_pix;

    always_comb begin
        head_valid = (skid_cnt_q != 2'd0) || pend_q;
        head       = (skid_cnt_q != 2'd0) ? skid0_q : fifo_dout_i[27:0];
        h_half     = head[27];
        h_y        = head[26:16];
        h_pix      = head[15:0];
    end

    // ------------------------------------------------------------------
    // Process stage
    // ------------------------------------------------------------------
    logic             accept;
    logic             new_line;
    logic [IDX_W-1:0] idx_sel;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx0_nxt;
    logic [IDX_W-1:0] idx1_nxt;
    logic             ovf;
    logic             wr;
    logic             complete;

    always_comb begin
        accept   = head_valid && !busy_q[h_y[0]];
        new_line = !cur_valid_q || (h_y != cur_y_q);
        if (new_line) begin
            idx_sel = '0;
        end else begin
            idx_sel = h_half ? idx1_q : idx0_q;
        end
        idx_inc  = idx_sel + IDX_W'(1);
        ovf      = accept && (idx_sel == IdxFull);
        wr       = accept && !ovf;

        idx0_nxt = new_line ? '0 : idx0_q;
        idx1_nxt = new_line ? '0 : idx1_q;
        if (wr) begin
            if (h_half) begin
                idx1_nxt = idx_inc;
            end else begin
                idx0_nxt = idx_inc;
            end
        end
        // Only the final write of a line can make both halves full.
        complete = wr && (idx0_nxt == IdxFull) && (idx1_nxt == IdxFull);
    end

    always_comb begin
        cur_y_d     = cur_y_q;
        cur_valid_d = cur_valid_q;
        idx0_d      = idx0_q;
        idx1_d      = idx1_q;
        lb_we_d     = wr;
        lb_bank_d   = lb_bank_q;
        lb_addr_d   = lb_addr_q;
        lb_data_d   = lb_data_q;
        line_done_d = complete;
        line_y_d    = line_y_q;
        line_bank_d = line_bank_q;
        line_drop_d = accept && new_line && cur_valid_q;
        pix_ovf_d   = ovf;

        if (accept) begin
            cur_y_d     = h_y;
            cur_valid_d = !complete;
            idx0_d      = idx0_nxt;
            idx1_d      = idx1_nxt;
        end

        if (wr) begin
            lb_bank_d = h_y[0];
            lb_data_d = h_pix;
            if (h_half) begin
                lb_addr_d = HalfBase + ADDR_W'(idx_sel);
            end else begin
                lb_addr_d = ADDR_W'(idx_sel);
            end
        end

        if (complete) begin
            line_y_d    = h_y;
            line_bank_d = h_y[0];
        end

        // A set in the same cycle as a release of that bank takes priority.
        busy_d = (busy_q & ~bank_release_i) | (complete ? (2'b01 << h_y[0]) : 2'b00);
    end

    // ------------------------------------------------------------------
    // Skid buffer update
    // ------------------------------------------------------------------
    logic [27:0] slot0, slot1, slot2;

    always_comb begin
        slot0 = skid0_q;
        slot1 = skid1_q;
        slot2 = fifo_dout_i[27:0];
        // Arriving word is appended behind the entries already held.
        if (skid_cnt_q == 2'd0) begin
            slot0 = fifo_dout_i[27:0];
        end else if (skid_cnt_q == 2'd1) begin
            slot1 = fifo_dout_i[27:0];
        end

        pend_d = fifo_rd_en_o;
        if (accept) begin
            skid0_d    = slot1;
            skid1_d    = slot2;
            skid_cnt_d = occ - 2'd1;
        end else begin
            skid0_d    = slot0;
            skid1_d    = slot1;
            skid_cnt_d = occ;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk125_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            skid0_q     <= '0;
            skid1_q     <= '0;
            skid_cnt_q  <= '0;
            pend_q      <= 1'b0;
            cur_y_q     <= '0;
            cur_valid_q <= 1'b0;
            idx0_q      <= '0;
            idx1_q      <= '0;
            lb_we_q     <= 1'b0;
            lb_bank_q   <= 1'b0;
            lb_addr_q   <= '0;
            lb_data_q   <= '0;
            line_done_q <= 1'b0;
            line_y_q    <= '0;
            line_bank_q <= 1'b0;
            busy_q      <= '0;
            line_drop_q <= 1'b0;
            pix_ovf_q   <= 1'b0;
        end else begin
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            skid_cnt_q  <= skid_cnt_d;
            pend_q      <= pend_d;
            cur_y_q     <= cur_y_d;
            cur_valid_q <= cur_valid_d;
            idx0_q      <= idx0_d;
            idx1_q      <= idx1_d;
            lb_we_q     <= lb_we_d;
            lb_bank_q   <= lb_bank_d;
            lb_addr_q   <= lb_addr_d;
            lb_data_q   <= lb_data_d;
            line_done_q <= line_done_d;
            line_y_q    <= line_y_d;
            line_bank_q <= line_bank_d;
            busy_q      <= busy_d;
            line_drop_q <= line_drop_d;
            pix_ovf_q   <= pix_ovf_d;
        end
    end

    assign lb_we_o     = lb_we_q;
    assign lb_bank_o   = lb_bank_q;
    assign lb_addr_o   = lb_addr_q;
    assign lb_data_o   = lb_data_q;
    assign line_done_o = line_done_q;
    assign line_y_o    = line_y_q;
    assign line_bank_o = line_bank_q;
    assign bank_busy_o = busy_q;
    assign line_drop_o = line_drop_q;
    assign pix_ovf_o   = pix_ovf_q;

endmodule
